mem_access_stage: RTL and testbench

//  Memory-access pipeline stage that sits directly upstream of instruction write-back.
//  It takes the execute-stage ALU result and store data, and runs one load or store
//  per instruction over a valid/ready data-cache port. For loads it aligns and

---
 rtl/mem_access_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access pipeline stage between execute and write-back
module mem_access_stage #(
   parameter int XLEN   = 64,
   parameter int STRB_W = XLEN / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_module_enable,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   alu_result,
   input  logic [XLEN-1:0]   store_data,
   input  logic              wb_ready,
   output logic              dcache_req_valid,
   input  logic              dcache_req_ready,
   output logic [XLEN-1:0]   dcache_req_addr,
   output logic              dcache_req_we,
   output logic [XLEN-1:0]   dcache_req_wdata,
   output logic [STRB_W-1:0] dcache_req_wstrb,
   input  logic              dcache_resp_valid,
   input  logic [XLEN-1:0]   dcache_resp_data,
   output logic [XLEN-1:0]   loaded_data,
   output logic [XLEN-1:0]   alu_result_out,
   output logic              mem_done,
   output logic              misaligned_fault
);

   localparam int         OFF_W    = $clog2(STRB_W);
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } state_t;

   state_t              state_q;
   logic [2:0]          funct3_q;
   logic [OFF_W-1:0]    off_q;
   logic                req_valid_q;
   logic [XLEN-1:0]     req_addr_q;
   logic                req_we_q;
   logic [XLEN-1:0]     req_wdata_q;
   logic [STRB_W-1:0]   req_wstrb_q;
   logic [XLEN-1:0]     loaded_data_q;
   logic [XLEN-1:0]     alu_result_out_q;
   logic                mem_done_q;
   logic                misaligned_q;

   logic                is_load;
   logic                is_store;
   logic [OFF_W-1:0]    off_d;
   logic                misaligned_d;
   logic [XLEN-1:0]     req_addr_d;
   logic [XLEN-1:0]     req_wdata_d;
   logic [STRB_W-1:0]   req_wstrb_d;
   logic [XLEN-1:0]     resp_shifted;
   logic [XLEN-1:0]     load_data_d;

   // Decode the incoming instruction: memory class, byte offset and alignment check.
   always_comb begin
      is_load      = (opcode == OP_LOAD);
      is_store     = (opcode == OP_STORE);
      off_d        = alu_result[OFF_W-1:0];
      misaligned_d = 1'b0;
      // funct3[1:0] encodes the access size for both loads and stores.
      case (funct3[1:0])
         2'b01:   misaligned_d = off_d[0];
         2'b10:   misaligned_d = |off_d[1:0];
         2'b11:   misaligned_d = |off_d;
         default: misaligned_d = 1'b0;
      endcase
   end

   // Build the cache request: dword-aligned address, lane-shifted data and byte strobes.
   always_comb begin
      req_addr_d  = {alu_result[XLEN-1:OFF_W], {OFF_W{1'b0}}};
      req_wdata_d = store_data << {off_d, 3'b000};
      req_wstrb_d = '0;
      case (funct3[1:0])
         2'b00:   req_wstrb_d = STRB_W'(8'h01) << off_d;
         2'b01:   req_wstrb_d = STRB_W'(8'h03) << off_d;
         2'b10:   req_wstrb_d = STRB_W'(8'h0F) << off_d;
         default: req_wstrb_d = '1;
      endcase
   end

   // Align the returned dword to the accessed byte and sign- or zero-extend it.
   always_comb begin
      resp_shifted = dcache_resp_data >> {off_q, 3'b000};
      load_data_d  = resp_shifted;
      case (funct3_q)
         3'b000:  load_data_d = {{(XLEN-8){resp_shifted[7]}}, resp_shifted[7:0]};
         3'b001:  load_data_d = {{(XLEN-16){resp_shifted[15]}}, resp_shifted[15:0]};
         3'b010:  load_data_d = {{(XLEN-32){resp_shifted[31]}}, resp_shifted[31:0]};
         3'b100:  load_data_d = {{(XLEN-8){1'b0}}, resp_shifted[7:0]};
         3'b101:  load_data_d = {{(XLEN-16){1'b0}}, resp_shifted[15:0]};
         3'b110:  load_data_d = {{(XLEN-32){1'b0}}, resp_shifted[31:0]};
         default: load_data_d = resp_shifted;
      endcase
   end

   // Control FSM; every output is a register updated only here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= S_IDLE;
         funct3_q         <= '0;
         off_q            <= '0;
         req_valid_q      <= 1'b0;
         req_addr_q       <= '0;
         req_we_q         <= 1'b0;
         req_wdata_q      <= '0;
         req_wstrb_q      <= '0;
         loaded_data_q    <= '0;
         alu_result_out_q <= '0;
         mem_done_q       <= 1'b0;
         misaligned_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mem_module_enable) begin
                  alu_result_out_q <= alu_result;
                  loaded_data_q    <= '0;
                  funct3_q         <= funct3;
                  off_q            <= off_d;
                  if ((is_load || is_store) && !misaligned_d) begin
                     // Loads carry no write data or strobes on the request.
                     req_valid_q <= 1'b1;
                     req_addr_q  <= req_addr_d;
                     req_we_q    <= is_store;
                     req_wdata_q <= is_store ? req_wdata_d : '0;
                     req_wstrb_q <= is_store ? req_wstrb_d : '0;
                     state_q     <= S_REQ;
                  end else begin
                     // Pass-through ops and faulting accesses skip the cache entirely.
                     misaligned_q <= (is_load || is_store) && misaligned_d;
                     mem_done_q   <= 1'b1;
                     state_q      <= S_DONE;
                  end
               end
            end
            S_REQ: begin
               if (dcache_req_ready) begin
                  req_valid_q <= 1'b0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (dcache_resp_valid) begin
                  // A store response is only an acknowledge; its data is meaningless.
                  loaded_data_q <= req_we_q ? '0 : load_data_d;
                  mem_done_q    <= 1'b1;
                  state_q       <= S_DONE;
               end
            end
            S_DONE: begin
               if (wb_ready) begin
                  mem_done_q    <= 1'b0;
                  misaligned_q  <= 1'b0;
                  loaded_data_q <= '0;
                  state_q       <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign dcache_req_valid = req_valid_q;
   assign dcache_req_addr  = req_addr_q;
   assign dcache_req_we    = req_we_q;
   assign dcache_req_wdata = req_wdata_q;
   assign dcache_req_wstrb = req_wstrb_q;
   assign loaded_data      = loaded_data_q;
   assign alu_result_out   = alu_result_out_q;
   assign mem_done         = mem_done_q;
   assign misaligned_fault = misaligned_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_module_enable;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [63:0] alu_result;
   logic [63:0] store_data;
   logic        wb_ready;
   logic        dcache_req_valid;
   logic        dcache_req_ready;
   logic [63:0] dcache_req_addr;
   logic        dcache_req_we;
   logic [63:0] dcache_req_wdata;
   logic [7:0]  dcache_req_wstrb;
   logic        dcache_resp_valid;
   logic [63:0] dcache_resp_data;
   logic [63:0] loaded_data;
   logic [63:0] alu_result_out;
   logic        mem_done;
   logic        misaligned_fault;

   typedef struct packed {
      logic [63:0] ld;
      logic [63:0] alu;
      logic        mis;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   mem_access_stage dut (
      .clk               (clk),
      .reset             (reset),
      .mem_module_enable (mem_module_enable),
      .opcode            (opcode),
      .funct3            (funct3),
      .alu_result        (alu_result),
      .store_data        (store_data),
      .wb_ready          (wb_ready),
      .dcache_req_valid  (dcache_req_valid),
      .dcache_req_ready  (dcache_req_ready),
      .dcache_req_addr   (dcache_req_addr),
      .dcache_req_we     (dcache_req_we),
      .dcache_req_wdata  (dcache_req_wdata),
      .dcache_req_wstrb  (dcache_req_wstrb),
      .dcache_resp_valid (dcache_resp_valid),
      .dcache_resp_data  (dcache_resp_data),
      .loaded_data       (loaded_data),
      .alu_result_out    (alu_result_out),
      .mem_done          (mem_done),
      .misaligned_fault  (misaligned_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_valid"}, 64'(dcache_req_valid), 64'd0);
      check({tag, "_loaded"}, loaded_data, 64'd0);
      check({tag, "_alu_out"}, alu_result_out, 64'd0);
      check({tag, "_done"}, 64'(mem_done), 64'd0);
      check({tag, "_fault"}, 64'(misaligned_fault), 64'd0);
      check({tag, "_wstrb"}, 64'(dcache_req_wstrb), 64'd0);
   endtask

   // Present one instruction for one edge, then scramble inputs to show they are ignored.
   task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] sdata);
      opcode            = op;
      funct3            = f3;
      alu_result        = addr;
      store_data        = sdata;
      mem_module_enable = 1'b1;
      @(negedge clk);
      mem_module_enable = 1'b0;
      opcode            = OP_LOAD;
      funct3            = 3'b111;
      alu_result        = 64'hDEAD_BEEF_0000_0001;
      store_data        = '1;
   endtask

   // Act as the cache: hold ready low, accept, then answer one cycle later.
   task automatic serve(input int ready_delay, input logic [63:0] rdata,
                        input logic [63:0] exp_addr, input logic exp_we,
                        input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb);
      for (int i = 0; i < ready_delay; i++) begin
         check("req_valid_hold", 64'(dcache_req_valid), 64'd1);
         check("req_addr_hold", dcache_req_addr, exp_addr);
         check("req_wstrb_hold", 64'(dcache_req_wstrb), 64'(exp_wstrb));
         @(negedge clk);
      end
      check("req_valid", 64'(dcache_req_valid), 64'd1);
      check("req_addr", dcache_req_addr, exp_addr);
      check("req_we", 64'(dcache_req_we), 64'(exp_we));
      check("req_wdata", dcache_req_wdata, exp_wdata);
      check("req_wstrb", 64'(dcache_req_wstrb), 64'(exp_wstrb));
      dcache_req_ready = 1'b1;
      @(negedge clk);
      dcache_req_ready = 1'b0;
      check("req_valid_drop", 64'(dcache_req_valid), 64'd0);
      check("done_early", 64'(mem_done), 64'd0);
      dcache_resp_valid = 1'b1;
      dcache_resp_data  = rdata;
      @(negedge clk);
      dcache_resp_valid = 1'b0;
      dcache_resp_data  = '0;
   endtask

   // Wait (bounded) for mem_done, then compare against the oldest expected result.
   task automatic pop_check(input string tag);
      exp_t e;
      int   n = 0;
      while (!mem_done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, 64'(mem_done), 64'd1);
      if (sb_q.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_loaded"}, loaded_data, e.ld);
         check({tag, "_alu_out"}, alu_result_out, e.alu);
         check({tag, "_fault"}, 64'(misaligned_fault), 64'(e.mis));
      end
   endtask

   // With wb_ready high the stage must leave DONE on the next edge.
   task automatic leave(input string tag);
      @(negedge clk);
      check({tag, "_done_clr"}, 64'(mem_done), 64'd0);
      check({tag, "_fault_clr"}, 64'(misaligned_fault), 64'd0);
      check({tag, "_loaded_clr"}, loaded_data, 64'd0);
   endtask

   initial begin
      reset             = 1'b1;
      mem_module_enable = 1'b0;
      opcode            = '0;
      funct3            = '0;
      alu_result        = '0;
      store_data        = '0;
      wb_ready          = 1'b1;
      dcache_req_ready  = 1'b0;
      dcache_resp_valid = 1'b0;
      dcache_resp_data  = '0;
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // 1: pass-through op completes one cycle after enable
      sb_q.push_back('{ld: 64'd0, alu: 64'h1234, mis: 1'b0});
      issue(OP_ALU, 3'b000, 64'h1234, 64'd0);
      check("alu_latency1", 64'(mem_done), 64'd1);
      check("alu_no_req", 64'(dcache_req_valid), 64'd0);
      pop_check("alu");
      leave("alu");

      // 2: LB sign-extends, LBU zero-extends
      sb_q.push_back('{ld: 64'hFFFF_FFFF_FFFF_FF80, alu: 64'h1003, mis: 1'b0});
      issue(OP_LOAD, 3'b000, 64'h1003, 64'd0);
      serve(0, 64'h0000_0000_8000_0000, 64'h1000, 1'b0, 64'd0, 8'h00);
      check("lb_latency3", 64'(mem_done), 64'd1);
      pop_check("lb");
      leave("lb");

      sb_q.push_back('{ld: 64'h80, alu: 64'h1003, mis: 1'b0});
      issue(OP_LOAD, 3'b100, 64'h1003, 64'd0);
      serve(0, 64'h0000_0000_8000_0000, 64'h1000, 1'b0, 64'd0, 8'h00);
      pop_check("lbu");
      leave("lbu");

      // 3: SH with ready held low for three cycles
      sb_q.push_back('{ld: 64'd0, alu: 64'h2006, mis: 1'b0});
      issue(OP_STORE, 3'b001, 64'h2006, 64'hBEEF);
      serve(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2000, 1'b1, 64'hBEEF_0000_0000_0000, 8'hC0);
      pop_check("sh");
      leave("sh");

      // SB in a middle lane
      sb_q.push_back('{ld: 64'd0, alu: 64'h4005, mis: 1'b0});
      issue(OP_STORE, 3'b000, 64'h4005, 64'hAB);
      serve(1, 64'd0, 64'h4000, 1'b1, 64'h0000_AB00_0000_0000, 8'h20);
      pop_check("sb");
      leave("sb");

      // LW / LWU from the upper word
      sb_q.push_back('{ld: 64'hFFFF_FFFF_8000_0001, alu: 64'h3004, mis: 1'b0});
      issue(OP_LOAD, 3'b010, 64'h3004, 64'd0);
      serve(0, 64'h8000_0001_1234_5678, 64'h3000, 1'b0, 64'd0, 8'h00);
      pop_check("lw");
      leave("lw");

      sb_q.push_back('{ld: 64'h0000_0000_8000_0001, alu: 64'h3004, mis: 1'b0});
      issue(OP_LOAD, 3'b110, 64'h3004, 64'd0);
      serve(0, 64'h8000_0001_1234_5678, 64'h3000, 1'b0, 64'd0, 8'h00);
      pop_check("lwu");
      leave("lwu");

      // 4: misaligned LW faults without a request
      sb_q.push_back('{ld: 64'd0, alu: 64'h3002, mis: 1'b1});
      issue(OP_LOAD, 3'b010, 64'h3002, 64'd0);
      check("mis_latency1", 64'(mem_done), 64'd1);
      check("mis_no_req", 64'(dcache_req_valid), 64'd0);
      pop_check("mis");
      leave("mis");
      check("mis_no_req_after", 64'(dcache_req_valid), 64'd0);

      // 5: LD held in DONE while write-back stalls
      wb_ready = 1'b0;
      sb_q.push_back('{ld: 64'h0123_4567_89AB_CDEF, alu: 64'h5008, mis: 1'b0});
      issue(OP_LOAD, 3'b011, 64'h5008, 64'd0);
      serve(0, 64'h0123_4567_89AB_CDEF, 64'h5008, 1'b0, 64'd0, 8'h00);
      pop_check("ld");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("ld_hold_done", 64'(mem_done), 64'd1);
         check("ld_hold_data", loaded_data, 64'h0123_4567_89AB_CDEF);
      end
      wb_ready = 1'b1;
      leave("ld");

      // 6: reset in WAIT, then a stale response in IDLE
      issue(OP_LOAD, 3'b011, 64'h6000, 64'd0);
      check("rst_req_valid", 64'(dcache_req_valid), 64'd1);
      dcache_req_ready = 1'b1;
      @(negedge clk);
      dcache_req_ready = 1'b0;
      reset = 1'b1;
      #1;
      check_all_zero("rst_async");
      @(negedge clk);
      reset             = 1'b0;
      dcache_resp_valid = 1'b1;
      dcache_resp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      dcache_resp_valid = 1'b0;
      dcache_resp_data  = '0;
      check_all_zero("stale_resp");
      sb_q.push_back('{ld: 64'd0, alu: 64'h77, mis: 1'b0});
      issue(OP_ALU, 3'b000, 64'h77, 64'd0);
      check("post_rst_latency1", 64'(mem_done), 64'd1);
      pop_check("post_rst");
      leave("post_rst");

      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
